// File: rtl/divmod_seq.sv
// divmod_seq: restoring unsigned divider, one quotient bit per clock; DIV_BY_ZERO_FLAG_EN adds div_err
package parameters;
   localparam int input_size  = 8;
   localparam int output_size = 16;
endpackage

module divmod_seq
   import parameters::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic [output_size-1:0] dividend,
   input  logic [input_size-1:0]  divisor,
   output logic                   busy,
   output logic                   done,
   output logic [output_size-1:0] quotient,
   output logic [input_size-1:0]  remainder
`ifdef DIV_BY_ZERO_FLAG_EN
   ,
   output logic                   div_err
`endif
);
   localparam int CNT_W = $clog2(output_size + 1);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t                 state, state_n;
   logic [output_size-1:0] sh, sh_n;
   logic [input_size-1:0]  dvs, pr, pr_n;
   logic [input_size:0]    trial;
   logic [CNT_W-1:0]       cnt;
   logic                   ge, accept, last;
   // one restoring step: sh shifts the dividend out at the top and the quotient in at the bottom;
   // pr stays below the divisor, so it fits input_size bits except for a zero divisor, where only
   // the low bits matter and end up holding dividend[input_size-1:0]
   always_comb begin
      trial  = {pr, sh[output_size-1]};
      ge     = trial >= {1'b0, dvs};
      pr_n   = ge ? input_size'(trial - {1'b0, dvs}) : trial[input_size-1:0];
      sh_n   = {sh[output_size-2:0], ge};
      accept = start && state != RUN;
      last   = state == RUN && cnt == CNT_W'(1);
   end
   // state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else state <= state_n;
   end
   // next state and handshake outputs
   always_comb begin
      state_n = state;
      busy    = 1'b0;
      done    = 1'b0;
      state_n = state == RUN ? (last ? DONE : RUN) : (start ? RUN : IDLE);
      busy    = state == RUN;
      done    = state == DONE;
   end
   // operand capture, iteration and result load on the edge entering DONE
   always_ff @(posedge clk) begin
      if (reset) begin
         sh        <= '0;
         dvs       <= '0;
         pr        <= '0;
         cnt       <= '0;
         quotient  <= '0;
         remainder <= '0;
`ifdef DIV_BY_ZERO_FLAG_EN
         div_err   <= 1'b0;
`endif
      end else if (accept) begin
         sh  <= dividend;
         dvs <= divisor;
         pr  <= '0;
         cnt <= CNT_W'(output_size);
      end else if (state == RUN) begin
         sh  <= sh_n;
         pr  <= pr_n;
         cnt <= cnt - CNT_W'(1);
         if (last) begin
            quotient  <= sh_n;
            remainder <= pr_n;
`ifdef DIV_BY_ZERO_FLAG_EN
            div_err   <= dvs == '0;
`endif
         end
      end
   end
endmodule
